shift_seq: RTL

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/shift_seq.sv
// Iterative 32-bit shifter/rotator: moves the operand one bit per cycle
// through IDLE -> SHIFT -> DONE, with a registered result held between operations.
module shift_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  func,
  input  logic [31:0] in,
  input  logic [4:0]  amt,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    OP_SLL   = 3'b000,
    OP_SRL   = 3'b001,
    OP_SRA   = 3'b010,
    OP_ROL   = 3'b011,
    OP_ROR   = 3'b100,
    OP_PASS5 = 3'b101,
    OP_PASS6 = 3'b110,
    OP_PASS7 = 3'b111
  } op_t;

  state_t      r_state;
  state_t      w_state_nxt;
  op_t         r_op;
  logic [31:0] r_work;
  logic [4:0]  r_cnt;
  logic [31:0] r_out;
  logic [31:0] w_step;
  logic        w_fast;

  // Zero amount or a pass-through code completes without entering SHIFT.
  always_comb begin
    w_fast = (amt == '0) || (func > OP_ROR);
  end

  // One-bit step of the work register for the captured operation.
  always_comb begin
    w_step = r_work;
    case (r_op)
      OP_SLL:  w_step = {r_work[30:0], 1'b0};
      OP_SRL:  w_step = {1'b0, r_work[31:1]};
      OP_SRA:  w_step = {r_work[31], r_work[31:1]};
      OP_ROL:  w_step = {r_work[30:0], r_work[31]};
      OP_ROR:  w_step = {r_work[0], r_work[31:1]};
      default: w_step = r_work;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_fast ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == 5'd1) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_SLL;
      r_work  <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work <= in;
            r_cnt  <= amt;
            r_op   <= op_t'(func);
            if (w_fast) begin
              r_out <= in;
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_step;
          r_cnt  <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_out <= w_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign out  = r_out;

endmodule
